// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a parametrised word memory, with programmable
// wait states, byte strobes and an error response for out-of-range accesses.
module apb_mem_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     paddr,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [DATA_WIDTH-1:0]     pwdata,
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pready,
   output logic                      pslverr
);

   // state  | meaning
   // IDLE   | no transfer in flight; waiting for a setup phase
   // ACCESS | transfer captured; counting wait states, then completing

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BSH    = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                  state;
   logic [3:0]              wait_cnt;
   logic                    wr_q;
   logic                    in_range_q;
   logic [IDX_W-1:0]        idx_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   offset;
   logic [ADDR_WIDTH-1:0]   index_full;
   logic [IDX_W-1:0]        idx;
   logic                    in_range;

   // Low byte-offset bits drop out in the shift, so unaligned addresses
   // simply map onto the containing word.
   assign offset     = paddr - BASE_ADDR;
   assign index_full = offset >> BSH;
   assign idx        = index_full[IDX_W-1:0];
   assign in_range   = (paddr >= BASE_ADDR) && (index_full < ADDR_WIDTH'(DEPTH));

   assign pready  = (state == ACCESS) && (wait_cnt == 4'(WAIT_STATES));
   assign pslverr = pready && !in_range_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         prdata     <= '0;
         wr_q       <= 1'b0;
         in_range_q <= 1'b0;
         idx_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  state      <= ACCESS;
                  wait_cnt   <= '0;
                  wr_q       <= pwrite;
                  idx_q      <= idx;
                  in_range_q <= in_range;
                  prdata     <= (!pwrite && in_range) ? mem[idx] : '0;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state <= IDLE;
               end else if (pready) begin
                  if (penable) begin
                     state <= IDLE;
                     // Write data and strobes are taken at the completing edge.
                     if (wr_q && in_range_q) begin
                        for (int b = 0; b < NBYTES; b++) begin
                           if (pstrb[b]) begin
                              mem[idx_q][8*b +: 8] <= pwdata[8*b +: 8];
                           end
                        end
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomised and directed checks of apb_mem_slave against a word-array model;
// one instance with no wait states and one with three.
module tb_apb_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] paddr;
   logic        psel0, psel1;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1;
   logic        pslverr0, pslverr1;

   int checks = 0;
   int errs   = 0;

   logic [31:0] model [2][32];

   always #5 clk = ~clk;

   apb_mem_slave #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel0), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

   apb_mem_slave #(.WAIT_STATES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel1), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

   function automatic logic rdy(input int d);
      return (d != 0) ? pready1 : pready0;
   endfunction

   function automatic logic err(input int d);
      return (d != 0) ? pslverr1 : pslverr0;
   endfunction

   function automatic logic [31:0] rdat(input int d);
      return (d != 0) ? prdata1 : prdata0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++) model[d][i] = '0;
   endtask

   task automatic idle();
      @(negedge clk);
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
   endtask

   // Full transfer on instance d; expected data, error and cycle count come from the model.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
      int          n;
      int          idx;
      bit          inr;
      logic [31:0] exp_rd;
      idx = int'(addr >> 2);
      inr = (addr < 32'd128);
      exp_rd = (!wr && inr) ? model[d][idx] : 32'h0;
      @(negedge clk);
      psel0 = (d == 0); psel1 = (d == 1);
      penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = $urandom; pstrb = 4'($urandom);
      chk("setup_pready", 64'(rdy(d)), 64'd0);
      @(negedge clk);
      penable = 1'b1; pwdata = data; pstrb = strb;
      n = 2;
      while (!rdy(d) && n < 40) begin
         chk("wait_pslverr", 64'(err(d)), 64'd0);
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'(2 + ((d != 0) ? 3 : 0)));
      chk("prdata", 64'(rdat(d)), 64'(exp_rd));
      chk("pslverr", 64'(err(d)), 64'(!inr));
      if (wr && inr)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[d][idx][8*b +: 8] = data[8*b +: 8];
      @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          d;
      bit          wr;
      logic [31:0] a;

      rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      clear_model();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_pready0", 64'(pready0), 64'd0);
      chk("rst_pslverr0", 64'(pslverr0), 64'd0);
      chk("rst_prdata0", 64'(prdata0), 64'd0);
      chk("rst_pready1", 64'(pready1), 64'd0);
      chk("rst_prdata1", 64'(prdata1), 64'd0);

      for (int i = 0; i < 32; i++) xfer(0, 1'b0, 32'(i * 4), '0, '0);
      idle();

      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      xfer(0, 1'b0, 32'h10, '0, '0);
      chk("deadbeef", 64'(prdata0), 64'hDEADBEEF);
      xfer(0, 1'b1, 32'h10, 32'h00000011, 4'h1);
      xfer(0, 1'b0, 32'h10, '0, '0);
      chk("strb_lane0", 64'(prdata0), 64'hDEADBE11);
      idle();

      xfer(1, 1'b0, 32'h10, '0, '0);
      idle();

      xfer(0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
      xfer(0, 1'b0, 32'h80, '0, '0);
      xfer(1, 1'b1, 32'h84, 32'h12345678, 4'hF);
      xfer(0, 1'b0, 32'h00, '0, '0);

      xfer(0, 1'b1, 32'h4, 32'h5, 4'hF);
      xfer(0, 1'b0, 32'h4, '0, '0);
      chk("b2b_raw", 64'(prdata0), 64'h5);

      // Abort: psel dropped during the access phase of a write to 0x8.
      @(negedge clk);
      psel0 = 1'b1; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
      pwdata = 32'hAAAA5555; pstrb = 4'hF;
      @(negedge clk);
      psel0 = 1'b0; penable = 1'b1;
      @(negedge clk);
      chk("abort_pready", 64'(pready0), 64'd0);
      penable = 1'b0;
      xfer(0, 1'b0, 32'h8, '0, '0);
      idle();

      // Reset during the access phase of a write to 0x0C.
      @(negedge clk);
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
      @(negedge clk);
      penable = 1'b1; pwdata = 32'h0BADF00D; pstrb = 4'hF; rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_pready", 64'(pready0), 64'd0);
      rst_n = 1'b1; psel0 = 1'b0; penable = 1'b0;
      clear_model();
      xfer(0, 1'b0, 32'hC, '0, '0);
      xfer(0, 1'b0, 32'h10, '0, '0);
      idle();

      for (int k = 0; k < 200; k++) begin
         d  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 36 * 4 - 1));
         xfer(d, wr, a, $urandom, 4'($urandom));
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      for (int dd = 0; dd < 2; dd++)
         for (int i = 0; i < 32; i++) xfer(dd, 1'b0, 32'(i * 4), '0, '0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB4 completer fronting a parametrised on-chip word memory; successor to the fixed 32x32 APB memory slave.
- Adds configurable width/depth/base address, programmable wait states (PREADY), byte strobes (PSTRB) and error response (PSLVERR) for out-of-range accesses.
- Sits on the peripheral APB bus behind the bridge; one completer per PSEL.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16, 32 or 64.
- DEPTH, 32, number of DATA_WIDTH words; power of two, >= 2.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0, extra ACCESS cycles with pready low before completion; 0..15.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- paddr  input  ADDR_WIDTH  byte address.
- psel  input  1  slave select.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  byte write strobes.
- prdata  output  DATA_WIDTH  read data, valid when pready=1 on a read.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response, valid only with pready=1.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0, all DEPTH words cleared to 0. Reset overrides any in-flight transfer; that transfer does not write memory.
- Address decode: offset = paddr - BASE_ADDR; index = offset >> log2(DATA_WIDTH/8).
  - In range iff paddr >= BASE_ADDR and index < DEPTH.
  - Low byte-offset bits are ignored; no misalignment error.
- FSM states: IDLE, ACCESS.
  - IDLE: pready=0. psel=1 and penable=0 (setup phase) -> ACCESS at next edge. Same edge captures pwrite, index and in-range flag, clears the wait counter, and loads prdata: mem[index] for an in-range read, 0 otherwise.
  - ACCESS: pready=1 combinationally while wait counter == WAIT_STATES; otherwise the counter increments each cycle with pready=0.
  - ACCESS completion: at the edge where psel=1, penable=1 and pready=1 -> IDLE.
  - ACCESS abort: psel=0 (protocol violation) -> IDLE at the next edge; no write, no response.
- Latency: a zero-wait transfer takes 2 cycles (setup + access). Each wait state adds 1 access cycle.
- Write commit: on the completing edge only, for a captured write that is in range. Byte lane b of mem[index] is updated from pwdata[8b+7:8b] iff pstrb[b]=1. pstrb=0 is a legal no-op write.
- Out of range:
  - pslverr=1 together with pready=1.
  - Writes are suppressed; reads return prdata=0.
  - Wait states still apply.
- pslverr=0 whenever pready=0. prdata holds its value between transfers.
- Back-to-back: after completion the FSM is in IDLE. A new setup may be presented in the very next cycle, so each transfer needs at least 2 cycles.
- Read-after-write to the same word in consecutive transfers returns the new data, since the read captures at its setup edge, after the write commits.
- pwdata and pstrb are sampled at the completing edge, not at setup.

Test Plan:
- Reset, then read index 0..DEPTH-1 (defaults, WAIT_STATES=0) -> every prdata=0, pready high on the 2nd cycle of each transfer, pslverr=0.
- Write 0xDEADBEEF to paddr 0x10 with pstrb=0xF, then read 0x10 -> prdata=0xDEADBEEF. Write 0x00000011 with pstrb=0x1, read again -> prdata=0xDEADBE11.
- WAIT_STATES=3: a single read -> pready low for the first 3 access cycles, high on the 4th; total 5 cycles from setup to completion.
- Write paddr=DEPTH*4 (0x80) -> pready=1, pslverr=1, memory unchanged. Read 0x80 -> prdata=0, pslverr=1.
- Back-to-back write 0x5 to 0x4 then read 0x4 with no idle cycle -> read returns 0x5. Then drop psel mid-ACCESS of a write to 0x8 -> FSM back to IDLE, read of 0x8 returns 0.
- Assert rst_n=0 during the ACCESS phase of a write to 0x0C -> pready=0 the next cycle, and a subsequent read of 0x0C returns 0.
